// File: rtl/module_teclado.sv
// 4x4 matrix keypad scanner with press/release debounce and four-digit BCD entry.
// Digit outputs and listo feed the 7-segment display driver directly.
module module_teclado #(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CYC = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] unidades_out,
    output logic [3:0] decenas_out,
    output logic [3:0] centenas_out,
    output logic [3:0] millares_out,
    output logic       listo,
    output logic [3:0] tecla,
    output logic       tecla_valida
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        SCAN,
        REBOTE,
        SUELTA
    } estado_t;

    estado_t       estado_reg;
    logic [SW-1:0] scan_cnt_reg;
    logic [DW-1:0] deb_cnt_reg;
    logic [1:0]    col_reg;
    logic [3:0]    ref_reg;
    logic [2:0]    cuenta_reg;

    logic [3:0]    filas_m;
    logic [3:0]    filas_s;
    logic [3:0]    fila_baja;
    logic          una_baja;
    logic [1:0]    fila_idx;

    // Rows are asynchronous to clk: two flops per row before any decision is made.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    filas_m[gi] <= 1'b1;
                    filas_s[gi] <= 1'b1;
                end else begin
                    filas_m[gi] <= filas[gi];
                    filas_s[gi] <= filas_m[gi];
                end
            end
            assign fila_baja[gi] = ~filas_s[gi];
        end
    endgenerate

    assign una_baja = $onehot(fila_baja);

    always_comb begin
        fila_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!ref_reg[i]) begin
                fila_idx = 2'(i);
            end
        end
    end

    function automatic logic [3:0] codigo(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'd1;
            4'h1:    k = 4'd2;
            4'h2:    k = 4'd3;
            4'h3:    k = 4'd10;
            4'h4:    k = 4'd4;
            4'h5:    k = 4'd5;
            4'h6:    k = 4'd6;
            4'h7:    k = 4'd11;
            4'h8:    k = 4'd7;
            4'h9:    k = 4'd8;
            4'hA:    k = 4'd9;
            4'hB:    k = 4'd12;
            4'hC:    k = 4'd14;
            4'hD:    k = 4'd0;
            4'hE:    k = 4'd15;
            default: k = 4'd13;
        endcase
        return k;
    endfunction

    // The column is frozen outside SCAN so the accepted key stays observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_reg   <= SCAN;
            scan_cnt_reg <= '0;
            deb_cnt_reg  <= '0;
            col_reg      <= 2'd0;
            columnas     <= 4'b1110;
            ref_reg      <= 4'hF;
            tecla        <= 4'd0;
            tecla_valida <= 1'b0;
        end else begin
            tecla_valida <= 1'b0;
            case (estado_reg)
                SCAN: begin
                    if (filas_s != 4'hF) begin
                        ref_reg     <= filas_s;
                        deb_cnt_reg <= '0;
                        estado_reg  <= REBOTE;
                    end else if (scan_cnt_reg == SCAN_LAST) begin
                        scan_cnt_reg <= '0;
                        col_reg      <= col_reg + 2'd1;
                        columnas     <= {columnas[2:0], columnas[3]};
                    end else begin
                        scan_cnt_reg <= scan_cnt_reg + 1'b1;
                    end
                end
                REBOTE: begin
                    if ((filas_s != ref_reg) || !una_baja) begin
                        estado_reg <= SCAN;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        tecla        <= codigo(fila_idx, col_reg);
                        tecla_valida <= 1'b1;
                        deb_cnt_reg  <= '0;
                        estado_reg   <= SUELTA;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
                SUELTA: begin
                    if (filas_s != 4'hF) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        deb_cnt_reg  <= '0;
                        scan_cnt_reg <= '0;
                        col_reg      <= col_reg + 2'd1;
                        columnas     <= {columnas[2:0], columnas[3]};
                        estado_reg   <= SCAN;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
                default: estado_reg <= SCAN;
            endcase
        end
    end

    // Digit entry reacts to the registered pulse, so results appear one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unidades_out <= 4'd0;
            decenas_out  <= 4'd0;
            centenas_out <= 4'd0;
            millares_out <= 4'd0;
            cuenta_reg   <= 3'd0;
            listo        <= 1'b0;
        end else if (tecla_valida) begin
            if (tecla <= 4'd9) begin
                if (listo) begin
                    unidades_out <= tecla;
                    decenas_out  <= 4'd0;
                    centenas_out <= 4'd0;
                    millares_out <= 4'd0;
                    cuenta_reg   <= 3'd1;
                    listo        <= 1'b0;
                end else if (cuenta_reg < 3'd4) begin
                    millares_out <= centenas_out;
                    centenas_out <= decenas_out;
                    decenas_out  <= unidades_out;
                    unidades_out <= tecla;
                    cuenta_reg   <= cuenta_reg + 3'd1;
                end
            end else if (tecla == 4'd15) begin
                if (cuenta_reg != 3'd0) begin
                    listo <= 1'b1;
                end
            end else if (tecla == 4'd14) begin
                unidades_out <= 4'd0;
                decenas_out  <= 4'd0;
                centenas_out <= 4'd0;
                millares_out <= 4'd0;
                cuenta_reg   <= 3'd0;
                listo        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_module_teclado.sv
// Bench for module_teclado: keypad shorts rows to driven columns; a digit-queue model checks every cycle.
module tb_module_teclado;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int KMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] unidades_out, decenas_out, centenas_out, millares_out;
    logic       listo;
    logic [3:0] tecla;
    logic       tecla_valida;

    logic [15:0] pressed;
    logic        bounce_open;

    int         n_pass = 0;
    int         n_total = 0;
    int         n_pulse = 0;
    int         exp_key = 0;
    bit         pulse_allowed = 1'b1;
    logic [3:0] frozen_col = 4'hF;
    bit         done = 1'b0;

    int q[$];
    bit m_listo = 1'b0;
    int m_last = 0;
    int low_run = 0;
    bit prev_tv = 1'b0;

    module_teclado #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)) dut (
        .clk          (clk),
        .rst          (rst),
        .filas        (filas),
        .columnas     (columnas),
        .unidades_out (unidades_out),
        .decenas_out  (decenas_out),
        .centenas_out (centenas_out),
        .millares_out (millares_out),
        .listo        (listo),
        .tecla        (tecla),
        .tecla_valida (tecla_valida)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven.
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !columnas[c] && !bounce_open) begin
                    filas[r] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int m_digit(input int pos);
        if (pos < q.size()) return q[q.size()-1-pos];
        return 0;
    endfunction

    task automatic model_key(input int k);
        if (k <= 9) begin
            if (m_listo) begin
                q.delete();
                q.push_back(k);
                m_listo = 1'b0;
            end else if (q.size() < 4) begin
                q.push_back(k);
            end
        end else if (k == 15) begin
            if (q.size() > 0) m_listo = 1'b1;
        end else if (k == 14) begin
            q.delete();
            m_listo = 1'b0;
        end
    endtask

    function automatic int key_index(input int k);
        for (int i = 0; i < 16; i++) begin
            if (KMAP[i] == k) return i;
        end
        return 0;
    endfunction

    function automatic logic [3:0] col_mask(input int k);
        return ~(4'b0001 << (key_index(k) % 4));
    endfunction

    task automatic key_down(input int k);
        exp_key = k;
        pulse_allowed = 1'b1;
        @(posedge clk); #2;
        pressed[key_index(k)] = 1'b1;
    endtask

    task automatic wait_pulse(input int n0, output bit got);
        int t;
        t = 0;
        while (n_pulse == n0 && t < 300) begin
            @(posedge clk); #2;
            t++;
        end
        got = (n_pulse != n0);
        chk("pulse_arrived", got, 1);
    endtask

    task automatic hold_release(input int n0, input int hold, input bit got);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (got) chk("hold_frozen", columnas, frozen_col);
            #1;
        end
        chk("single_pulse", n_pulse - n0, 1);
        pressed = '0;
        if (got) begin
            for (int i = 0; i < DEB + 1; i++) begin
                @(posedge clk); #1;
                chk("release_frozen", columnas, frozen_col);
                #1;
            end
            @(posedge clk); #1;
            chk("release_advance", columnas, {frozen_col[2:0], frozen_col[3]});
            #1;
        end else begin
            repeat (DEB + 10) @(posedge clk);
            #2;
        end
    endtask

    task automatic press_key(input int k, input int hold, input bit bounce);
        int n0;
        bit got;
        n0 = n_pulse;
        key_down(k);
        if (bounce) begin
            for (int i = 0; i < 30; i++) begin
                if (i % 3 == 0) bounce_open = ~bounce_open;
                @(posedge clk); #2;
            end
            bounce_open = 1'b0;
            chk("bounce_no_pulse", n_pulse - n0, 0);
        end
        wait_pulse(n0, got);
        hold_release(n0, hold, got);
        $display("key %0d: tecla=%0d digits=%0d%0d%0d%0d listo=%0d", k, tecla,
                 millares_out, centenas_out, decenas_out, unidades_out, listo);
    endtask

    task automatic press_two(input int c, input int r1, input int r2);
        int n0;
        n0 = n_pulse;
        pulse_allowed = 1'b0;
        @(posedge clk); #2;
        pressed[r1*4+c] = 1'b1;
        pressed[r2*4+c] = 1'b1;
        repeat (60) @(posedge clk);
        #2;
        chk("two_keys_no_pulse", n_pulse - n0, 0);
        pressed = '0;
        repeat (DEB + 10) @(posedge clk);
        #2;
        pulse_allowed = 1'b1;
        $display("two keys col %0d rows %0d,%0d: pulses=%0d", c, r1, r2, n_pulse - n0);
    endtask

    task automatic check_reset_now(input string tag);
        chk({tag, "_columnas"}, columnas, 4'b1110);
        chk({tag, "_unidades"}, unidades_out, 0);
        chk({tag, "_decenas"}, decenas_out, 0);
        chk({tag, "_centenas"}, centenas_out, 0);
        chk({tag, "_millares"}, millares_out, 0);
        chk({tag, "_listo"}, listo, 0);
        chk({tag, "_tecla_valida"}, tecla_valida, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pressed = '0;
        bounce_open = 1'b0;
        fork
            begin : monitor
                while (!done) begin
                    @(negedge clk);
                    if (rst) begin
                        q.delete();
                        m_listo = 1'b0;
                        m_last = 0;
                        prev_tv = 1'b0;
                        continue;
                    end
                    if (filas != 4'hF) low_run++;
                    else low_run = 0;
                    chk("columnas_onehot", $countones(~columnas), 1);
                    chk("unidades", unidades_out, m_digit(0));
                    chk("decenas", decenas_out, m_digit(1));
                    chk("centenas", centenas_out, m_digit(2));
                    chk("millares", millares_out, m_digit(3));
                    chk("listo", listo, m_listo);
                    if (tecla_valida) begin
                        n_pulse++;
                        chk("pulse_expected", pulse_allowed, 1);
                        chk("pulse_width", prev_tv, 0);
                        chk("pulse_column", columnas, col_mask(exp_key));
                        chk("pulse_debounced", low_run >= DEB + 4, 1);
                        frozen_col = columnas;
                        m_last = exp_key;
                        model_key(exp_key);
                    end
                    chk("tecla", tecla, m_last);
                    prev_tv = tecla_valida;
                end
            end
            begin : stimulus
                int t, n0, k, sel, r1;
                bit got;
                repeat (3) @(posedge clk);
                #1;
                check_reset_now("reset");
                chk("reset_tecla", tecla, 0);
                #1;
                rst = 1'b0;

                press_key(5, 30, 1'b0);
                chk("lit_single_5", unidades_out, 5);

                press_key(14, 12, 1'b0);
                press_key(1, 12, 1'b0);
                press_key(2, 12, 1'b0);
                press_key(3, 12, 1'b0);
                press_key(4, 12, 1'b0);
                press_key(9, 12, 1'b0);
                press_key(15, 12, 1'b0);
                chk("lit_entry_millares", millares_out, 1);
                chk("lit_entry_centenas", centenas_out, 2);
                chk("lit_entry_decenas", decenas_out, 3);
                chk("lit_entry_unidades", unidades_out, 4);
                chk("lit_entry_listo", listo, 1);

                press_key(7, 12, 1'b0);
                chk("lit_new_unidades", unidades_out, 7);
                chk("lit_new_decenas", decenas_out, 0);
                chk("lit_new_listo", listo, 0);
                press_key(14, 12, 1'b0);
                chk("lit_clear_unidades", unidades_out, 0);
                press_key(15, 12, 1'b0);
                chk("lit_hash_empty_listo", listo, 0);

                press_key(8, 15, 1'b1);
                chk("lit_bounce_unidades", unidades_out, 8);

                press_two(0, 0, 1);
                press_key(10, 12, 1'b0);
                chk("lit_A_tecla", tecla, 10);
                chk("lit_A_unidades", unidades_out, 8);

                // Reset while scanning.
                t = 0;
                while (columnas == 4'b1110 && t < 20) begin
                    @(posedge clk); #2;
                    t++;
                end
                chk("scan_moved", columnas != 4'b1110, 1);
                rst = 1'b1;
                #1;
                check_reset_now("rst_mid");
                repeat (2) @(posedge clk);
                #2;
                rst = 1'b0;

                // Key held through reset is accepted once more afterwards.
                n0 = n_pulse;
                key_down(5);
                wait_pulse(n0, got);
                repeat (3) @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check_reset_now("rst_held");
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                n0 = n_pulse;
                wait_pulse(n0, got);
                hold_release(n0, 12, got);
                chk("lit_held_unidades", unidades_out, 5);

                for (int it = 0; it < 40; it++) begin
                    sel = $urandom_range(0, 9);
                    if (sel == 0) begin
                        r1 = $urandom_range(0, 3);
                        press_two($urandom_range(0, 3), r1, (r1 + $urandom_range(1, 3)) % 4);
                    end else begin
                        if (sel <= 6) k = $urandom_range(0, 9);
                        else k = $urandom_range(10, 15);
                        press_key(k, $urandom_range(10, 25), sel == 1);
                    end
                end
                done = 1'b1;
            end
        join
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
